// File: rtl/add8u_err_monitor_if.sv
// Sample handshake between the approximate-adder harness and the error monitor.
// Carries the operand pair, the approximate sum and the valid/ready pair.
interface add8u_err_monitor_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [8:0] O;

    modport master (output in_valid, output A, output B, output O, input in_ready);
    modport slave  (input in_valid, input A, input B, input O, output in_ready);
endinterface

// File: rtl/add8u_err_monitor.sv
// Error-statistics monitor for an 8-bit unsigned approximate adder.
// Stage 1 computes |exact - O| and its square; stage 2 accumulates windowed statistics.
module add8u_err_monitor #(
    parameter int CNT_W = 32,
    parameter int ABS_W = 40,
    parameter int SQ_W  = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [CNT_W-1:0]   window,
    add8u_err_monitor_if.slave bus,
    output logic [CNT_W-1:0]   n_samples,
    output logic [CNT_W-1:0]   n_err,
    output logic [ABS_W-1:0]   sum_abs,
    output logic [SQ_W-1:0]    sum_sq,
    output logic [8:0]         max_err,
    output logic [7:0]         max_a,
    output logic [7:0]         max_b,
    output logic               done,
    output logic               sat
);
    localparam int AW = ABS_W + 10;
    localparam int SW = SQ_W + 19;

    logic [CNT_W-1:0] r_window;
    logic             r_s1_valid;
    logic [7:0]       r_s1_a;
    logic [7:0]       r_s1_b;
    logic [8:0]       r_s1_err;
    logic [17:0]      r_s1_sq;

    logic [CNT_W-1:0] r_n_samples;
    logic [CNT_W-1:0] r_n_err;
    logic [ABS_W-1:0] r_sum_abs;
    logic [SQ_W-1:0]  r_sum_sq;
    logic [8:0]       r_max_err;
    logic [7:0]       r_max_a;
    logic [7:0]       r_max_b;
    logic             r_done;
    logic             r_sat;

    logic [8:0]       w_exact;
    logic [9:0]       w_diff;
    logic [9:0]       w_neg;
    logic [8:0]       w_err;
    logic [17:0]      w_sq;
    logic [CNT_W:0]   w_in_flight;
    logic             w_at_limit;
    logic             w_accept;

    logic [CNT_W:0]   w_ns_sum;
    logic [CNT_W-1:0] w_ns_next;
    logic [CNT_W:0]   w_ne_sum;
    logic [CNT_W-1:0] w_ne_next;
    logic [AW-1:0]    w_abs_sum;
    logic             w_abs_ovf;
    logic [ABS_W-1:0] w_abs_next;
    logic [SW-1:0]    w_sq_sum;
    logic             w_sq_ovf;
    logic [SQ_W-1:0]  w_sq_next;

    assign w_exact = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_diff  = {1'b0, w_exact} - {1'b0, bus.O};
    assign w_neg   = 10'd0 - w_diff;
    assign w_err   = w_diff[9] ? w_neg[8:0] : w_diff[8:0];
    assign w_sq    = {9'd0, w_err} * {9'd0, w_err};

    // Samples already in stage 1 count against the window so at most window are accepted.
    assign w_in_flight  = {1'b0, r_n_samples} + {{CNT_W{1'b0}}, r_s1_valid};
    assign w_at_limit   = (r_window != '0) && (w_in_flight >= {1'b0, r_window});
    assign bus.in_ready = !rst && !clear && !r_done && !w_at_limit;
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign w_ns_sum   = {1'b0, r_n_samples} + {{CNT_W{1'b0}}, 1'b1};
    assign w_ns_next  = w_ns_sum[CNT_W] ? '1 : w_ns_sum[CNT_W-1:0];
    assign w_ne_sum   = {1'b0, r_n_err} + {{CNT_W{1'b0}}, (r_s1_err != 9'd0)};
    assign w_ne_next  = w_ne_sum[CNT_W] ? '1 : w_ne_sum[CNT_W-1:0];
    assign w_abs_sum  = AW'(r_sum_abs) + AW'(r_s1_err);
    assign w_abs_ovf  = |w_abs_sum[AW-1:ABS_W];
    assign w_abs_next = w_abs_ovf ? '1 : w_abs_sum[ABS_W-1:0];
    assign w_sq_sum   = SW'(r_sum_sq) + SW'(r_s1_sq);
    assign w_sq_ovf   = |w_sq_sum[SW-1:SQ_W];
    assign w_sq_next  = w_sq_ovf ? '1 : w_sq_sum[SQ_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_window    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_err    <= '0;
            r_s1_sq     <= '0;
            r_n_samples <= '0;
            r_n_err     <= '0;
            r_sum_abs   <= '0;
            r_sum_sq    <= '0;
            r_max_err   <= '0;
            r_max_a     <= '0;
            r_max_b     <= '0;
            r_done      <= 1'b0;
            r_sat       <= 1'b0;
        end else if (clear) begin
            r_window    <= window;
            r_s1_valid  <= 1'b0;
            r_n_samples <= '0;
            r_n_err     <= '0;
            r_sum_abs   <= '0;
            r_sum_sq    <= '0;
            r_max_err   <= '0;
            r_max_a     <= '0;
            r_max_b     <= '0;
            r_done      <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a   <= bus.A;
                r_s1_b   <= bus.B;
                r_s1_err <= w_err;
                r_s1_sq  <= w_sq;
            end
            if (r_s1_valid && !r_done) begin
                r_n_samples <= w_ns_next;
                r_n_err     <= w_ne_next;
                r_sum_abs   <= w_abs_next;
                r_sum_sq    <= w_sq_next;
                // Strictly greater: ties keep the operands of the earlier sample.
                if (r_s1_err > r_max_err) begin
                    r_max_err <= r_s1_err;
                    r_max_a   <= r_s1_a;
                    r_max_b   <= r_s1_b;
                end
                if ((r_window != '0) && (w_ns_next == r_window)) begin
                    r_done <= 1'b1;
                end
                if (w_ns_sum[CNT_W] || w_ne_sum[CNT_W] || w_abs_ovf || w_sq_ovf) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign n_samples = r_n_samples;
    assign n_err     = r_n_err;
    assign sum_abs   = r_sum_abs;
    assign sum_sq    = r_sum_sq;
    assign max_err   = r_max_err;
    assign max_a     = r_max_a;
    assign max_b     = r_max_b;
    assign done      = r_done;
    assign sat       = r_sat;
endmodule
